// File: rtl/shared_inv_sbox_pipe.sv
// Two-share first-order threshold implementation of the uBlock inverse S-box, NIBBLES lanes per transfer.
// Optional output remask stage (latency 2) is built when INV_SBOX_REMASK_EN is defined.
module shared_inv_sbox_pipe #(
    parameter int NIBBLES = 32,
    parameter int GUARD_W = 10,
`ifdef INV_SBOX_REMASK_EN
    localparam int GPORT_W = GUARD_W*NIBBLES + 4*NIBBLES
`else
    localparam int GPORT_W = GUARD_W*NIBBLES
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*NIBBLES-1:0]   din_s0,
    input  logic [4*NIBBLES-1:0]   din_s1,
    input  logic                   rnd_valid,
    output logic                   rnd_ready,
    input  logic [GPORT_W-1:0]     guards,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*NIBBLES-1:0]   dout_s0,
    output logic [4*NIBBLES-1:0]   dout_s1
);

    // Per-lane component layout: [7:0] y0, [11:8] y1, [15:12] y2, [23:16] y3.
    // Component index = share tuple {i,j,k} (or {i,j}); tuples with i=0 compress into share 0.
    localparam int CW = 24;

    // y0 = ab ^ c ^ d ^ ad ^ abd ^ cd
    function automatic logic [7:0] comps_y0(input logic [3:0] s0, input logic [3:0] s1);
        logic [7:0] r;
        logic [3:0] xi, xj, xk;
        r = '0;
        for (int t = 0; t < 8; t++) begin
            xi = t[2] ? s1 : s0;
            xj = t[1] ? s1 : s0;
            xk = t[0] ? s1 : s0;
            r[t] = xi[0] & xj[1] & xk[3];
            if (t[0] == 1'b0) r[t] = r[t] ^ (xi[0] & xj[1]) ^ (xi[0] & xj[3]) ^ (xi[2] & xj[3]);
            if (t[1:0] == 2'b00) r[t] = r[t] ^ xi[2] ^ xi[3];
        end
        return r;
    endfunction

    // y3 = 1 ^ c ^ ac ^ bc ^ d ^ cd ^ acd
    function automatic logic [7:0] comps_y3(input logic [3:0] s0, input logic [3:0] s1);
        logic [7:0] r;
        logic [3:0] xi, xj, xk;
        r = '0;
        for (int t = 0; t < 8; t++) begin
            xi = t[2] ? s1 : s0;
            xj = t[1] ? s1 : s0;
            xk = t[0] ? s1 : s0;
            r[t] = xi[0] & xj[2] & xk[3];
            if (t[0] == 1'b0) r[t] = r[t] ^ (xi[0] & xj[2]) ^ (xi[1] & xj[2]) ^ (xi[2] & xj[3]);
            if (t[1:0] == 2'b00) r[t] = r[t] ^ xi[2] ^ xi[3];
            if (t == 0) r[t] = ~r[t];
        end
        return r;
    endfunction

    // y1 = a ^ b ^ d ^ ad
    function automatic logic [3:0] comps_y1(input logic [3:0] s0, input logic [3:0] s1);
        logic [3:0] r;
        logic [3:0] xi, xj;
        r = '0;
        for (int t = 0; t < 4; t++) begin
            xi = t[1] ? s1 : s0;
            xj = t[0] ? s1 : s0;
            r[t] = xi[0] & xj[3];
            if (t[0] == 1'b0) r[t] = r[t] ^ xi[0] ^ xi[1] ^ xi[3];
        end
        return r;
    endfunction

    // y2 = 1 ^ a ^ ab ^ c
    function automatic logic [3:0] comps_y2(input logic [3:0] s0, input logic [3:0] s1);
        logic [3:0] r;
        logic [3:0] xi, xj;
        r = '0;
        for (int t = 0; t < 4; t++) begin
            xi = t[1] ? s1 : s0;
            xj = t[0] ? s1 : s0;
            r[t] = xi[0] & xj[1];
            if (t[0] == 1'b0) r[t] = r[t] ^ xi[0] ^ xi[2];
            if (t == 0) r[t] = ~r[t];
        end
        return r;
    endfunction

    // Ring of 8 differences over the sequence g0,g1,g2,g3,g1,g2,g3,g0: cancels in total,
    // while each share's half still receives g0^g1.
    function automatic logic [7:0] ring8(input logic [3:0] g);
        logic [7:0] x;
        x = {g[0], g[3], g[2], g[1], g[3], g[2], g[1], g[0]};
        return x ^ {x[0], x[7:1]};
    endfunction

    logic                          accept;
    logic                          v1_q, v1_d;
    logic [NIBBLES-1:0][CW-1:0]    comp_q, comp_d;
    logic [4*NIBBLES-1:0]          cmp_s0, cmp_s1;

    always_comb begin
        comp_d = comp_q;
        if (accept) begin
            for (int n = 0; n < NIBBLES; n++) begin
                comp_d[n][7:0]   = comps_y0(din_s0[4*n +: 4], din_s1[4*n +: 4])
                                   ^ ring8(guards[n*GUARD_W +: 4]);
                comp_d[n][11:8]  = comps_y1(din_s0[4*n +: 4], din_s1[4*n +: 4])
                                   ^ {1'b0, guards[n*GUARD_W + 4], guards[n*GUARD_W + 4], 1'b0};
                comp_d[n][15:12] = comps_y2(din_s0[4*n +: 4], din_s1[4*n +: 4])
                                   ^ {1'b0, guards[n*GUARD_W + 5], guards[n*GUARD_W + 5], 1'b0};
                comp_d[n][23:16] = comps_y3(din_s0[4*n +: 4], din_s1[4*n +: 4])
                                   ^ ring8(guards[n*GUARD_W + 6 +: 4]);
            end
        end
    end

    // Compression reads registered components only.
    always_comb begin
        cmp_s0 = '0;
        cmp_s1 = '0;
        for (int n = 0; n < NIBBLES; n++) begin
            cmp_s0[4*n + 0] = ^comp_q[n][3:0];
            cmp_s1[4*n + 0] = ^comp_q[n][7:4];
            cmp_s0[4*n + 1] = ^comp_q[n][9:8];
            cmp_s1[4*n + 1] = ^comp_q[n][11:10];
            cmp_s0[4*n + 2] = ^comp_q[n][13:12];
            cmp_s1[4*n + 2] = ^comp_q[n][15:14];
            cmp_s0[4*n + 3] = ^comp_q[n][19:16];
            cmp_s1[4*n + 3] = ^comp_q[n][23:20];
        end
    end

    assign accept    = in_valid & rnd_valid & in_ready;
    assign rnd_ready = accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q   <= 1'b0;
            comp_q <= '0;
        end else begin
            v1_q   <= v1_d;
            comp_q <= comp_d;
        end
    end

`ifdef INV_SBOX_REMASK_EN
    logic                 v2_q, v2_d, can_load;
    logic [4*NIBBLES-1:0] m_q, m_d, s2_s0_q, s2_s0_d, s2_s1_q, s2_s1_d;

    assign can_load = !v2_q | out_ready;
    assign in_ready = !v1_q | can_load;

    always_comb begin
        v1_d    = v1_q;
        m_d     = m_q;
        v2_d    = v2_q;
        s2_s0_d = s2_s0_q;
        s2_s1_d = s2_s1_q;
        if (accept) begin
            v1_d = 1'b1;
            m_d  = guards[GUARD_W*NIBBLES +: 4*NIBBLES];
        end else if (can_load) begin
            v1_d = 1'b0;
        end
        if (can_load) begin
            v2_d = v1_q;
            if (v1_q) begin
                s2_s0_d = cmp_s0 ^ m_q;
                s2_s1_d = cmp_s1 ^ m_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q    <= 1'b0;
            m_q     <= '0;
            s2_s0_q <= '0;
            s2_s1_q <= '0;
        end else begin
            v2_q    <= v2_d;
            m_q     <= m_d;
            s2_s0_q <= s2_s0_d;
            s2_s1_q <= s2_s1_d;
        end
    end

    assign out_valid = v2_q;
    assign dout_s0   = s2_s0_q;
    assign dout_s1   = s2_s1_q;
`else
    assign in_ready = !v1_q | out_ready;

    always_comb begin
        v1_d = v1_q;
        if (accept)         v1_d = 1'b1;
        else if (out_ready) v1_d = 1'b0;
    end

    assign out_valid = v1_q;
    assign dout_s0   = cmp_s0;
    assign dout_s1   = cmp_s1;
`endif

endmodule

// File: tb/tb_shared_inv_sbox_pipe.sv
// Scoreboard bench for shared_inv_sbox_pipe: random masked stimulus, INV-table reference model.
// Handles both the default build and INV_SBOX_REMASK_EN (latency 2).
module tb_shared_inv_sbox_pipe;
    localparam int N  = 32;
    localparam int NW = 4*N;
`ifdef INV_SBOX_REMASK_EN
    localparam int GW  = 10*N + 4*N;
    localparam int LAT = 2;
`else
    localparam int GW  = 10*N;
    localparam int LAT = 1;
`endif
    localparam logic [3:0] INV_TAB [16] = '{4'hc, 4'ha, 4'he, 4'hd, 4'h1, 4'hf, 4'hb, 4'h0,
                                            4'h7, 4'h2, 4'h5, 4'h4, 4'h3, 4'h6, 4'h9, 4'h8};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready;
    logic [NW-1:0] din_s0, din_s1, dout_s0, dout_s1;
    logic [GW-1:0] guards;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [NW-1:0] exp_q [$];

    shared_inv_sbox_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .din_s0(din_s0), .din_s1(din_s1),
        .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .guards(guards),
        .out_valid(out_valid), .out_ready(out_ready),
        .dout_s0(dout_s0), .dout_s1(dout_s1)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [NW-1:0] model(input logic [NW-1:0] x);
        logic [NW-1:0] y;
        for (int n = 0; n < N; n++) y[4*n +: 4] = INV_TAB[x[4*n +: 4]];
        return y;
    endfunction

    function automatic logic [NW-1:0] rand_vec();
        logic [NW-1:0] v;
        for (int i = 0; i < NW/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [GW-1:0] rand_guards();
        logic [GW-1:0] v;
        for (int i = 0; i < GW/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic monitor();
        logic [NW-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (out_valid && out_ready) begin
                    pops++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_output", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("share_xor", dout_s0 ^ dout_s1, e);
                    end
                end
                if (in_valid && rnd_valid && in_ready)
                    exp_q.push_back(model(din_s0 ^ din_s1));
`ifndef INV_SBOX_REMASK_EN
                chk("in_ready_rule", in_ready, !out_valid || out_ready);
`endif
            end
        end
    endtask

    task automatic present(input logic [NW-1:0] x);
        logic [NW-1:0] s0;
        s0        = rand_vec();
        in_valid  = 1'b1;
        rnd_valid = 1'b1;
        din_s0    = s0;
        din_s1    = s0 ^ x;
        guards    = rand_guards();
    endtask

    task automatic idle();
        in_valid  = 1'b0;
        rnd_valid = 1'b0;
    endtask

    // Waits for the current input to be accepted; returns at the accepting edge + 1.
    task automatic wait_accept();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (in_ready && rnd_valid && in_valid) done = 1'b1;
        end
        chk("accept_timeout", done, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [NW-1:0] x, s0, h0, h1;
        bit            found, pend;
        int            p0;
        rst_n = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b1;
        din_s0 = '0; din_s1 = '0; guards = '0;
        fork monitor(); join_none

        repeat (3) @(posedge clk); #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout_s0", dout_s0, 0);
        chk("rst_dout_s1", dout_s1, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        chk("post_rst_rnd_ready", rnd_ready, 0);
        @(posedge clk); #1;

        // exhaustive x by share-0 mask on lane 0, other lanes random
        for (int xv = 0; xv < 16; xv++) begin
            for (int m = 0; m < 16; m++) begin
                x = rand_vec();
                x[3:0] = xv[3:0];
                s0 = rand_vec();
                s0[3:0] = m[3:0];
                in_valid = 1'b1; rnd_valid = 1'b1;
                din_s0 = s0; din_s1 = s0 ^ x; guards = rand_guards();
                wait_accept();
                idle();
                for (int k = 1; k <= LAT; k++) begin
                    @(negedge clk);
                    chk("latency", out_valid, (k == LAT));
                end
                if (k_is_spot(xv, m)) chk("spot_lane0", (dout_s0 ^ dout_s1) & 128'hf, INV_TAB[xv]);
                @(posedge clk); #1;
            end
        end

        // back-to-back
        p0 = pops;
        for (int i = 0; i < 64 + LAT; i++) begin
            if (i < 64) present(rand_vec()); else idle();
            @(negedge clk);
            if (i < 64)   chk("b2b_in_ready", in_ready, 1);
            if (i >= LAT) chk("b2b_no_bubble", out_valid, 1);
            @(posedge clk); #1;
        end
        chk("b2b_count", pops - p0, 64);
        repeat (2) @(posedge clk); #1;

        // stall
        out_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            present(rand_vec());
            @(negedge clk);
            if (!in_ready) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("stall_reached", found, 1);
        h0 = dout_s0; h1 = dout_s1;
        for (int k = 0; k < 5; k++) begin
            chk("stall_in_ready", in_ready, 0);
            chk("stall_rnd_ready", rnd_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_dout_s0", dout_s0, h0);
            chk("stall_dout_s1", dout_s1, h1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_in_ready", in_ready, 1);
        chk("release_out_valid", out_valid, 1);
        @(posedge clk); #1;
        idle();
        repeat (LAT + 2) @(posedge clk);
        @(negedge clk);
        chk("drained", out_valid, 0);
        @(posedge clk); #1;

        // rnd_valid low with input pending
        present(rand_vec());
        wait_accept();
        present(rand_vec());
        rnd_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("norand_rnd_ready", rnd_ready, 0);
            if (k == 3) chk("norand_out_valid", out_valid, 0);
        end
        @(posedge clk); #1;
        rnd_valid = 1'b1;
        wait_accept();
        idle();
        repeat (LAT + 2) @(posedge clk); #1;

        // reset mid-stall
        out_ready = 1'b0;
        present(rand_vec());
        wait_accept();
        idle();
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge clk);
            if (out_valid) found = 1'b1;
        end
        chk("pre_rst_out_valid", found, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_dout_s0", dout_s0, 0);
        chk("midrst_dout_s1", dout_s1, 0);
        @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        p0 = pops;
        present(rand_vec());
        wait_accept();
        idle();
        repeat (LAT + 2) @(posedge clk); #1;
        chk("midrst_first_result", pops - p0, 1);

        // fixed x, random masks/guards, random handshakes
        x = rand_vec();
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!pend) begin
                if ($urandom_range(3) != 0) begin
                    present(x);
                    pend = 1'b1;
                end else in_valid = 1'b0;
            end
            rnd_valid = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(3) != 0);
            @(negedge clk);
            if (in_valid && rnd_valid && in_ready) pend = 1'b0;
            @(posedge clk); #1;
        end
        idle();
        out_ready = 1'b1;
        repeat (LAT + 3) @(posedge clk); #1;
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // spot values named for boundary inputs: x=0, x=7, x=f with zero lane-0 mask
    function automatic bit k_is_spot(input int xv, input int m);
        return (m == 0) && (xv == 0 || xv == 7 || xv == 15);
    endfunction

endmodule
